// File: rtl/cnt_ctrl_pkg.sv
// Shared types and constants for the enable-counter sequencer.
// The helper gives the modulo-256 distance the counter has travelled since a run began.
package cnt_ctrl_pkg;

   localparam int CNT_W = 8;

   typedef enum logic [1:0] {IDLE, RUN, HOLD, DONE} cnt_ctrl_st_t;

   function automatic logic [CNT_W-1:0] cntDelta(input logic [CNT_W-1:0] now,
                                                 input logic [CNT_W-1:0] base);
      return now - base;
   endfunction

endpackage

// File: rtl/cnt_ctrl_if.sv
// Control/feedback bundle between the register layer, the sequencer and the counter.
// The master drives run requests and counter feedback; the slave (sequencer) drives en/busy/done.
interface cnt_ctrl_if #(
   parameter int PW = 8
);

   logic                          start;
   logic                          stop;
   logic                          pause;
   logic                          periodic;
   logic [cnt_ctrl_pkg::CNT_W-1:0] term;
   logic [PW-1:0]                 presc;
   logic [cnt_ctrl_pkg::CNT_W-1:0] cnt;
   logic                          en;
   logic                          busy;
   logic                          done;

   modport master (
      output start, stop, pause, periodic, term, presc, cnt,
      input  en, busy, done
   );

   modport slave (
      input  start, stop, pause, periodic, term, presc, cnt,
      output en, busy, done
   );

endinterface

// File: rtl/cnt_ctrl_presc.sv
// Prescale divider: holds the captured prescale value and a phase counter.
// tick_o marks the last phase of each step interval.
module cnt_presc #(
   parameter int PW = 8
) (
   input  logic          clk,
   input  logic          rst_n,
   input  logic          load_i,
   input  logic          clear_i,
   input  logic          count_i,
   input  logic [PW-1:0] presc_i,
   output logic          tick_o
);

   logic [PW-1:0] presc_q, presc_d;
   logic [PW-1:0] pdiv_q, pdiv_d;

   assign tick_o = (pdiv_q == presc_q);

   // Clear wins over counting; when neither is asked for the phase simply holds.
   always_comb begin
      presc_d = presc_q;
      pdiv_d  = pdiv_q;
      if (load_i) begin
         presc_d = presc_i;
      end
      if (clear_i) begin
         pdiv_d = '0;
      end else if (count_i) begin
         pdiv_d = tick_o ? '0 : pdiv_q + 1'b1;
      end
   end

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         presc_q <= '0;
         pdiv_q  <= '0;
      end else begin
         presc_q <= presc_d;
         pdiv_q  <= pdiv_d;
      end
   end

endmodule

// File: rtl/cnt_ctrl.sv
// Sequencer for the 8-bit enable counter: issues term single-cycle en steps spaced by
// the prescaler, flags done, and optionally restarts periodically.
module cnt_ctrl
   import cnt_ctrl_pkg::*;
#(
   parameter int PW = 8
) (
   input  logic      clk,
   input  logic      rst_n,
   cnt_ctrl_if.slave ctrl_io
);

   cnt_ctrl_st_t     st_q;
   logic [CNT_W-1:0] base_q;
   logic [CNT_W-1:0] term_q;
   logic [CNT_W-1:0] steps_q;
   logic             per_q;
   logic             en_q;
   logic             busy_q;
   logic             done_q;

   logic startGo;
   logic runEdge;
   logic allIssued;
   logic restart;
   logic prescClear;
   logic prescCount;
   logic tick;
   logic issue;

   // A run edge is any RUN/HOLD edge without stop or pause, so HOLD resumes on the
   // very edge pause drops. In a periodic restart the DONE cycle also serves as the
   // first prescale phase of the next run, which keeps the period at term*(presc+1)+1.
   assign startGo    = (st_q == IDLE) && ctrl_io.start && !ctrl_io.stop && !ctrl_io.pause;
   assign runEdge    = ((st_q == RUN) || (st_q == HOLD)) && !ctrl_io.stop && !ctrl_io.pause;
   assign allIssued  = (steps_q == term_q);
   assign restart    = (st_q == DONE) && per_q && !ctrl_io.stop;
   assign prescClear = startGo || (runEdge && allIssued);
   assign prescCount = (runEdge && !allIssued) || (restart && !ctrl_io.pause);
   assign issue      = tick && ((runEdge && !allIssued) ||
                                (restart && !ctrl_io.pause && (term_q != '0)));

   cnt_presc #(.PW(PW)) u_presc (
      .clk     (clk),
      .rst_n   (rst_n),
      .load_i  (startGo),
      .clear_i (prescClear),
      .count_i (prescCount),
      .presc_i (ctrl_io.presc),
      .tick_o  (tick)
   );

   // Run FSM with registered en/busy/done; en and done default low every edge.
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         st_q    <= IDLE;
         base_q  <= '0;
         term_q  <= '0;
         steps_q <= '0;
         per_q   <= 1'b0;
         en_q    <= 1'b0;
         busy_q  <= 1'b0;
         done_q  <= 1'b0;
      end else begin
         en_q   <= 1'b0;
         done_q <= 1'b0;
         case (st_q)
            IDLE: begin
               if (startGo) begin
                  base_q  <= ctrl_io.cnt;
                  term_q  <= ctrl_io.term;
                  per_q   <= ctrl_io.periodic;
                  steps_q <= '0;
                  busy_q  <= 1'b1;
                  if (ctrl_io.term == '0) begin
                     st_q   <= DONE;
                     done_q <= 1'b1;
                  end else begin
                     st_q <= RUN;
                  end
               end
            end
            RUN, HOLD: begin
               if (ctrl_io.stop) begin
                  st_q   <= IDLE;
                  busy_q <= 1'b0;
               end else if (ctrl_io.pause) begin
                  st_q <= HOLD;
               end else if (allIssued) begin
                  st_q   <= DONE;
                  done_q <= 1'b1;
               end else begin
                  st_q <= RUN;
                  if (issue) begin
                     en_q    <= 1'b1;
                     steps_q <= steps_q + 1'b1;
                  end
               end
            end
            DONE: begin
               if (restart) begin
                  st_q    <= RUN;
                  base_q  <= ctrl_io.cnt;
                  steps_q <= issue ? CNT_W'(1) : '0;
                  en_q    <= issue;
               end else begin
                  st_q   <= IDLE;
                  busy_q <= 1'b0;
               end
            end
            default: begin
               st_q   <= IDLE;
               busy_q <= 1'b0;
            end
         endcase
      end
   end

   assign ctrl_io.en   = en_q;
   assign ctrl_io.busy = busy_q;
   assign ctrl_io.done = done_q;

`ifdef ASSERTS_SV
   aEnOnlyInRun: assert property (@(posedge clk) disable iff (!rst_n) en_q |-> (st_q == RUN));
   aDonePulse:   assert property (@(posedge clk) disable iff (!rst_n) done_q |=> !done_q);
   aDoneCount:   assert property (@(posedge clk) disable iff (!rst_n)
                    (st_q == DONE) |-> (cntDelta(ctrl_io.cnt, base_q) == term_q));
   aNoX:         assert property (@(posedge clk) disable iff (!rst_n)
                    !$isunknown({en_q, busy_q, done_q}));
`endif

endmodule
